accum_dump_scheduler: RTL and testbench
=======================================

Name: accum_dump_scheduler

Overview:
- Time-shares one W-bit adder among CH input channels. Each channel performs integrate-and-dump over LEN samples.
- Round-robin arbitration picks one channel sample per cycle and adds it into that channel's running sum.
- On the LEN-th sample the channel's total is dumped to a single-entry output register and the channel sum restarts from zero.
- Sits between per-channel sample sources and downstream decimated/filtered consumers in the DSP chain.

Parameters:
W, 32, sample and sum width in bits; sums wrap modulo 2^W.
CH, 4, number of requesting channels (2..16).
LEN, 8, samples integrated per dump (1..65535).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  CH  per-channel sample valid.
in_data  input  CH*W  per-channel samples; channel i occupies bits [i*W +: W].
in_ready  output  CH  one-hot-or-zero grant; a sample transfers when in_valid[i] & in_ready[i].
out_valid  output  1  dump register holds a result.
out_ready  input  1  downstream accepts the result.
out_data  output  W  dumped sum.
out_ch  output  max(1,clog2(CH))  channel index of out_data.

Behaviour:
- Reset is synchronous and active-high on clk. It clears:
  - all channel sums and sample counters to 0;
  - out_valid, out_data and out_ch to 0;
  - the round-robin pointer to 0.
  Reset mid-integration discards partial sums and any unaccepted result. in_ready is 0 during the reset cycle.
- Per-channel state: sum[i] (W bits) and cnt[i] (counts 0..LEN-1).
- Eligibility:
  - A channel is eligible when in_valid[i]=1 and it is not blocked.
  - A channel is blocked when cnt[i]==LEN-1 (its next sample completes a dump) and the output register cannot take a result this cycle, i.e. out_valid=1 and out_ready=0.
- Arbitration:
  - Combinational. in_ready[i] goes to the first eligible channel found scanning upward from ptr, wrapping at CH-1 to 0.
  - At most one in_ready bit is high per cycle. in_ready may depend combinationally on in_valid, out_valid and out_ready.
  - Sources must not make in_valid depend on in_ready.
- Pointer: after a transfer from channel g, ptr <= (g+1) mod CH. With no transfer, ptr holds.
- Accepted sample on channel g, non-final (cnt[g] < LEN-1): sum[g] <= sum[g] + in_data[g] (mod 2^W); cnt[g] <= cnt[g]+1.
- Accepted sample on channel g, final (cnt[g] == LEN-1):
  - out_data <= sum[g] + in_data[g] (mod 2^W); out_ch <= g; out_valid <= 1;
  - sum[g] <= 0; cnt[g] <= 0.
  - With LEN=1 every sample is final and out_data equals the sample.
- Latency: result is visible on out_data/out_valid the cycle after the final sample's handshake.
- Output handshake:
  - Result accepted when out_valid & out_ready. If no new dump happens in that cycle, out_valid <= 0.
  - Same-cycle accept plus new dump is allowed: the register reloads with the new result and out_valid stays 1. Full throughput is one dump per cycle.
  - While out_valid=1 and out_ready=0, out_data and out_ch hold stable.
- Backpressure never stalls non-final samples. Only dump-completing channels are masked, and the grant passes to the next eligible channel.
- Overflow wraps silently; no saturation, no flag.
- Channels with no pending valid keep their sums indefinitely; there is no timeout.

Test Plan:
1. W=32, CH=4, LEN=8, out_ready=1. Only ch2 valid with samples 1..8 → in_ready=4'b0100 each cycle; one result out_ch=2, out_data=36, out_valid high exactly 1 cycle, 1 cycle after the 8th handshake; ch2 sum restarts (next 8 samples of 10 → 80).
2. All 4 channels continuously valid, ch i sending constant i+1 → grants rotate 0,1,2,3,0,…; after 32 cycles dumps arrive in order ch0..ch3 with values 8,16,24,32.
3. ch0 at cnt=7 with out_valid=1, out_ready=0 → in_ready[0]=0 while ch1 non-final samples still granted; on out_ready=1, ch0 is granted the same cycle and out_data reloads next cycle.
4. Wrap: LEN=2, ch1 samples 0xFFFF_FFFF then 0x0000_0002 → out_data=0x0000_0001, out_ch=1.
5. Reset asserted mid-integration (ch3 cnt=5, sum=100, a pending unaccepted result) → next cycle out_valid=0, all in_ready=0 during reset; afterwards 8 samples of 1 on ch3 yield 8, not 108; first grant with all valid goes to ch0.
6. LEN=1, ch0 and ch1 valid, out_ready toggling 1/0 → every accepted sample appears as out_data one cycle later; no result is lost or duplicated (scoreboard count equals sample count).

Source files
------------

// File: rtl/accum_dump_scheduler_if.sv
// Sample-in / dump-out bus of the accumulate-and-dump scheduler.
// The slave modport is the scheduler side; the master modport is the environment side.
interface accum_dump_scheduler_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned CH = 4
);
  localparam int unsigned ChW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]   in_valid;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [ChW-1:0]  out_ch;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch
  );
endinterface

// File: rtl/accum_dump_scheduler.sv
// Round-robin time-shared integrate-and-dump over CH channels of LEN samples each.
// One adder serves whichever channel holds the grant; completed sums land in a
// single-entry output register.
module accum_dump_scheduler #(
  parameter int unsigned W   = 32,
  parameter int unsigned CH  = 4,
  parameter int unsigned LEN = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  accum_dump_scheduler_if.slave bus
);
  localparam int unsigned ChW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned CntW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LEN - 1);
  localparam logic [ChW-1:0]  ChLast  = ChW'(CH - 1);

  logic [W-1:0]    sum_q [CH];
  logic [W-1:0]    sum_d [CH];
  logic [CntW-1:0] cnt_q [CH];
  logic [CntW-1:0] cnt_d [CH];
  logic [ChW-1:0]  ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [ChW-1:0]  out_ch_q, out_ch_d;

  logic            out_free;
  logic [CH-1:0]   elig;
  logic            found;
  int unsigned     scan_idx;
  logic [ChW-1:0]  gnt_idx;
  logic [CH-1:0]   gnt;
  logic [W-1:0]    gnt_word;
  logic [W-1:0]    gnt_sum;

  // Grant: first eligible channel scanning upward from ptr; a channel whose next
  // sample would dump is masked while the output register is full and stalled.
  always_comb begin
    out_free = !out_valid_q || bus.out_ready;
    for (int unsigned i = 0; i < CH; i++) begin
      elig[i] = bus.in_valid[i] && (out_free || (cnt_q[i] != CntLast));
    end
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < CH; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= CH) scan_idx = scan_idx - CH;
      if (!found && elig[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = ChW'(scan_idx);
      end
    end
    gnt = '0;
    if (found && !reset) gnt[gnt_idx] = 1'b1;
  end

  // Shared adder and next-state for channel sums, counters, pointer and dump register.
  always_comb begin
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    gnt_word    = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (ChW'(i) == gnt_idx) gnt_word = bus.in_data[i*W +: W];
    end
    gnt_sum = sum_q[gnt_idx] + gnt_word;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (|gnt) begin
      ptr_d = (gnt_idx == ChLast) ? '0 : gnt_idx + ChW'(1);
      if (cnt_q[gnt_idx] == CntLast) begin
        // A dump in the same cycle as an accept simply reloads the register.
        out_valid_d    = 1'b1;
        out_data_d     = gnt_sum;
        out_ch_d       = gnt_idx;
        sum_d[gnt_idx] = '0;
        cnt_d[gnt_idx] = '0;
      end else begin
        sum_d[gnt_idx] = gnt_sum;
        cnt_d[gnt_idx] = cnt_q[gnt_idx] + CntW'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CH; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_accum_dump_scheduler.sv
// Directed bench: three schedulers (LEN=8, LEN=1, LEN=2) share stimulus; each
// vector names which one it checks.
module tb_accum_dump_scheduler;
  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [127:0] in_data;
  logic        out_ready;

  accum_dump_scheduler_if #(.W(32), .CH(4)) if8 ();
  accum_dump_scheduler_if #(.W(32), .CH(4)) if1 ();
  accum_dump_scheduler_if #(.W(32), .CH(4)) if2 ();

  assign if8.in_valid  = in_valid;
  assign if8.in_data   = in_data;
  assign if8.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_data   = in_data;
  assign if2.out_ready = out_ready;

  accum_dump_scheduler #(.W(32), .CH(4), .LEN(8)) u_d8 (.clk(clk), .reset(reset), .bus(if8));
  accum_dump_scheduler #(.W(32), .CH(4), .LEN(1)) u_d1 (.clk(clk), .reset(reset), .bus(if1));
  accum_dump_scheduler #(.W(32), .CH(4), .LEN(2)) u_d2 (.clk(clk), .reset(reset), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sel: 0 = LEN8, 1 = LEN1, 2 = LEN2. strict forces out_data/out_ch checks when out_valid=0.
  typedef struct {
    string       name;
    int          sel;
    bit          rst;
    logic [3:0]  vld;
    logic [31:0] d0, d1, d2, d3;
    bit          ordy;
    logic [3:0]  rdy;
    bit          ov;
    logic [31:0] od;
    logic [1:0]  och;
    bit          strict;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(string name, int sel, bit rst, logic [3:0] vld,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] d3, bit ordy, logic [3:0] rdy, bit ov,
                              logic [31:0] od, logic [1:0] och, bit strict);
    vec_t v;
    v.name = name; v.sel = sel; v.rst = rst; v.vld = vld;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.od = od; v.och = och; v.strict = strict;
    return v;
  endfunction

  task automatic read_dut(input int sel, output logic [3:0] rdy, output logic ov,
                          output logic [31:0] od, output logic [1:0] och);
    case (sel)
      1: begin rdy = if1.in_ready; ov = if1.out_valid; od = if1.out_data; och = if1.out_ch; end
      2: begin rdy = if2.in_ready; ov = if2.out_valid; od = if2.out_data; och = if2.out_ch; end
      default: begin
        rdy = if8.in_ready; ov = if8.out_valid; od = if8.out_data; och = if8.out_ch;
      end
    endcase
  endtask

  // Called 1 time unit after a rising edge: drive, settle, compare, advance one cycle.
  task automatic apply(input vec_t v);
    logic [3:0]  rdy;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  och;
    bit          ok;
    reset     = v.rst;
    in_valid  = v.vld;
    in_data   = {v.d3, v.d2, v.d1, v.d0};
    out_ready = v.ordy;
    #1;
    read_dut(v.sel, rdy, ov, od, och);
    ok = (rdy == v.rdy) && (ov == v.ov);
    if (v.ov || v.strict) ok = ok && (od == v.od) && (och == v.och);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got in_ready=%b out_valid=%b out_data=%0d out_ch=%0d, want in_ready=%b out_valid=%b out_data=%0d out_ch=%0d",
               v.name, rdy, ov, od, och, v.rdy, v.ov, v.od, v.och);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    // Test 1: ch2 alone, 1..8 -> 36, then eight 10s -> 80.
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk("t1_ch2_a", 0, 0, 4'b0100, 0, 0, 32'(k + 1), 0, 1, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk("t1_dump36", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 36, 2, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk("t1_ch2_b", 0, 0, 4'b0100, 0, 0, 10, 0, 1, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk("t1_dump80", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 80, 2, 0));
    tbl.push_back(mk("t1_hold", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 80, 2, 1));
    // Test 2: all valid, ch i sends i+1; rotation from reset, dumps 8/16/24/32.
    tbl.push_back(mk("t2_rst", 0, 1, 4'b1111, 1, 2, 3, 4, 1, 4'b0000, 0, 0, 0, 0));
    for (int j = 0; j < 32; j++)
      tbl.push_back(mk("t2_rot", 0, 0, 4'b1111, 1, 2, 3, 4, 1, 4'b0001 << (j % 4),
                       j >= 29, 32'((j - 28) * 8), 2'(j - 29), 0));
    tbl.push_back(mk("t2_dump32", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 32, 3, 0));
    tbl.push_back(mk("t2_idle", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));

    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply(mk("rst_state8", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1));
    apply(mk("rst_state1", 1, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1));
    apply(mk("rst_state2", 2, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Test 3: ch0 at its final sample is masked under backpressure; ch1 keeps going.
    apply(mk("t3_rst", 0, 1, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++)
      apply(mk("t3_ch0", 0, 0, 4'b0001, 1, 0, 0, 0, 1, 4'b0001, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      apply(mk("t3_ch1", 0, 0, 4'b0010, 0, 2, 0, 0, 1, 4'b0010, 0, 0, 0, 0));
    apply(mk("t3_block_a", 0, 0, 4'b0011, 1, 2, 0, 0, 0, 4'b0010, 1, 16, 1, 0));
    apply(mk("t3_block_b", 0, 0, 4'b0011, 1, 2, 0, 0, 0, 4'b0010, 1, 16, 1, 0));
    apply(mk("t3_release", 0, 0, 4'b0011, 1, 2, 0, 0, 1, 4'b0001, 1, 16, 1, 0));
    apply(mk("t3_reload", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 8, 0, 0));
    apply(mk("t3_idle", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));

    // Test 4: LEN=2 wraparound.
    apply(mk("t4_rst", 2, 1, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));
    apply(mk("t4_s0", 2, 0, 4'b0010, 0, 32'hFFFF_FFFF, 0, 0, 1, 4'b0010, 0, 0, 0, 0));
    apply(mk("t4_s1", 2, 0, 4'b0010, 0, 32'h0000_0002, 0, 0, 1, 4'b0010, 0, 0, 0, 0));
    apply(mk("t4_wrap", 2, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 32'h0000_0001, 1, 0));

    // Test 5: reset mid-integration with a pending unaccepted result.
    apply(mk("t5_rst0", 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      apply(mk("t5_ch0", 0, 0, 4'b0001, 1, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      apply(mk("t5_ch3", 0, 0, 4'b1000, 0, 0, 0, 20, 0, 4'b1000, 1, 8, 0, 0));
    apply(mk("t5_ch1", 0, 0, 4'b0010, 0, 5, 0, 0, 0, 4'b0010, 1, 8, 0, 0));
    apply(mk("t5_rst_cyc", 0, 1, 4'b1111, 1, 1, 1, 1, 0, 4'b0000, 1, 8, 0, 0));
    apply(mk("t5_after", 0, 0, 4'b1111, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0, 1));
    for (int k = 0; k < 8; k++)
      apply(mk("t5_ch3_new", 0, 0, 4'b1000, 0, 0, 0, 1, 1, 4'b1000, 0, 0, 0, 0));
    apply(mk("t5_fresh8", 0, 0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 1, 8, 3, 0));

    // Test 6: LEN=1, toggling out_ready, checked against a reference model.
    apply(mk("t6_rst", 1, 1, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));
    begin
      int          ptr_m, g, n_in, n_out;
      bit          ov_m;
      logic [31:0] od_m;
      logic [1:0]  och_m;
      logic [3:0]  exp_rdy, rdy;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  och;
      logic [31:0] dat [4];
      bit          ok;
      ptr_m = 0; ov_m = 0; od_m = 0; och_m = 0; n_in = 0; n_out = 0;
      for (int k = 0; k < 26; k++) begin
        reset     = 1'b0;
        in_valid  = (k < 20) ? {2'b00, (k % 3) != 0, 1'b1} : 4'b0000;
        out_ready = (k < 20) ? ((k % 2) == 0) : 1'b1;
        dat[0] = 32'(100 + k); dat[1] = 32'(200 + k); dat[2] = 0; dat[3] = 0;
        in_data = {dat[3], dat[2], dat[1], dat[0]};
        #1;
        g = -1;
        if (!(ov_m && !out_ready)) begin
          for (int j = 0; j < 4; j++)
            if (g < 0 && in_valid[(ptr_m + j) % 4]) g = (ptr_m + j) % 4;
        end
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        read_dut(1, rdy, ov, od, och);
        ok = (rdy == exp_rdy) && (ov == ov_m);
        if (ov_m) ok = ok && (od == od_m) && (och == och_m);
        n_vec++;
        if (!ok) begin
          n_bad++;
          $display("FAIL t6_cycle%0d: got in_ready=%b out_valid=%b out_data=%0d out_ch=%0d, want in_ready=%b out_valid=%b out_data=%0d out_ch=%0d",
                   k, rdy, ov, od, och, exp_rdy, ov_m, od_m, och_m);
        end
        if (ov_m && out_ready) n_out++;
        if (g >= 0) begin
          n_in++;
          od_m = dat[g]; och_m = 2'(g); ov_m = 1'b1; ptr_m = (g + 1) % 4;
        end else if (out_ready) begin
          ov_m = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      n_vec++;
      if (n_in != n_out || n_in == 0) begin
        n_bad++;
        $display("FAIL t6_scoreboard: got %0d results delivered, want %0d samples accepted",
                 n_out, n_in);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
